fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch stage directly upstream of the IF/ID instruction register of the 16-bit SIMPLE pipeline.
- Owns the fetch PC and drives the synchronous instruction RAM, which has 1-cycle read latency.
- Buffers fetched words in a small FIFO and presents one instruction per cycle, with its PC+1, to decode under a valid/ready handshake.
- Handles branch redirect (flush), the decode hazard stall, and halt/run gating.

Parameters:
- DEPTH, 4, queue entries; power of two, >=2
- AW, 16, instruction address width
- NOP_INST, 16'h0000, word driven on inst_out when no valid entry (bubble)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- run  in  1  fetch enable (exec asserted and not halted); 0 = issue no new fetches
- redirect  in  1  branch taken; single-cycle pulse
- redirect_pc  in  AW  branch target, sampled when redirect=1
- imem_addr  out  AW  instruction RAM address
- imem_rd  out  1  request issued this cycle
- imem_q  in  16  RAM data, valid one cycle after imem_rd
- out_valid  out  1  inst_out holds a real instruction
- out_ready  in  1  decode accepts (0 while the load-use hazard stalls)
- inst_out  out  16  head instruction, or NOP_INST when out_valid=0
- pc1_out  out  AW  address of the head instruction plus 1
- level  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset values: fetch_pc=0, queue empty, level=0, out_valid=0, inst_out=NOP_INST, pc1_out=0, imem_rd=0, in-flight flag=0, epoch=0.
- imem_addr is always fetch_pc.
- Issue condition: imem_rd = run & ~redirect & (level + inflight - pop < DEPTH), where pop = out_valid & out_ready. The credit therefore includes the one outstanding read, and the queue can never overflow.
- On issue: fetch_pc <= fetch_pc+1, modulo 2^AW (0xFFFF wraps to 0x0000). Record inflight=1, tagged with the current epoch and the issuing pc+1.
- Response: one cycle after issue, if the recorded epoch equals the current epoch, push {imem_q, tag_pc1}. Otherwise discard the response.
- Output: inst_out and pc1_out come combinationally from the head entry. out_valid = (level != 0).
- Pop when out_valid & out_ready.
- Push and pop in the same cycle: level is unchanged, and this is legal when full.
- Empty with a response arriving: data appears on out_valid the cycle after the push. There is no bypass, so fetch-to-decode latency is 2 cycles.
- Redirect has highest priority:
  - Flush the queue (level=0, pointers reset).
  - fetch_pc <= redirect_pc.
  - Toggle epoch so any in-flight response is dropped.
  - No issue in the redirect cycle; fetch resumes next cycle from redirect_pc.
  - A pop coinciding with redirect is ignored; the flushed head is not delivered.
- run=0: issue stops and fetch_pc holds. An in-flight response still lands, and draining continues. Run toggling never loses or duplicates an instruction.
- reset asserted mid-operation overrides redirect, push and pop in that cycle.
- Read and write pointers wrap modulo DEPTH.

Decomposition:
- Shared pipeline package holds:
  - NOP_INST encoding
  - instruction width (16)
  - AW
  - the queue entry struct {inst[15:0], pc1[AW-1:0]}
- One natural sub-module: sync_fifo, a DEPTH-deep, width-parameterised FIFO with synchronous reset, flush, push/pop and level output.
- fetch_queue keeps the PC, epoch, in-flight tracking and issue/credit logic.

Test Plan:
- Reset then run=1, out_ready=1, RAM word[n]=16'h1000+n -> first out_valid at cycle 2 with inst_out=16'h1000, pc1_out=1. Then one instruction per cycle in order with no gaps.
- out_ready=0 from cycle 3 for 10 cycles -> level saturates at 4 with at most 4 issues pending. imem_rd=0 once credit is exhausted. On release, instructions 0x1001.. are delivered with none lost or duplicated.
- redirect=1, redirect_pc=16'h0040 while queue holds 3 entries and 1 read is in flight -> next cycle level=0 and imem_addr=0x0040. The stale response is dropped. Next delivered inst_out=16'h1040, pc1_out=0x0041.
- Start fetch at 16'hFFFE via redirect -> delivers pc1_out=0xFFFF, then 0x0000, then 0x0001 (wrap).
- run=0 for 5 cycles with queue non-empty and out_ready=1 -> queue drains to level=0 with out_valid=0 and inst_out=NOP_INST. Re-assert run -> fetch continues from the held fetch_pc.
- reset=1 asserted while full and with redirect=1 in the same cycle -> next cycle level=0, out_valid=0, fetch_pc=0, and no stale response is pushed afterwards.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the SIMPLE pipeline fetch stage: instruction width,
// address width, bubble encoding and the queued entry layout.
package fetch_queue_pkg;

  localparam int FQ_INST_W = 16;
  localparam int FQ_AW     = 16;

  localparam logic [FQ_INST_W-1:0] FQ_NOP_INST = 16'h0000;

  // One buffered fetch: the instruction word and the address after it.
  typedef struct packed {
    logic [FQ_INST_W-1:0] inst;
    logic [FQ_AW-1:0]     pc1;
  } fq_entry_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int fq_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch stage bus: instruction RAM request/response plus the valid/ready
// delivery towards decode. master = fetch stage, slave = RAM + decode side.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int AW = FQ_AW
) ();

  logic [AW-1:0]        imem_addr;
  logic                 imem_rd;
  logic [FQ_INST_W-1:0] imem_q;
  logic                 out_valid;
  logic                 out_ready;
  logic [FQ_INST_W-1:0] inst_out;
  logic [AW-1:0]        pc1_out;

  modport master (
    output imem_addr, imem_rd, out_valid, inst_out, pc1_out,
    input  imem_q, out_ready
  );

  modport slave (
    input  imem_addr, imem_rd, out_valid, inst_out, pc1_out,
    output imem_q, out_ready
  );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Small register-based FIFO with synchronous reset and flush. The head word
// is presented combinationally so the consumer sees it in the same cycle
// the occupancy becomes non-zero.
module sync_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = fq_level_w(DEPTH)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          do_push;
  logic          do_pop;
  logic          full;

  // Qualify requests: flush wins, pop needs data, push needs room unless
  // a pop frees a slot in the same cycle.
  always_comb begin
    full    = (level_reg == LW'(DEPTH));
    do_pop  = pop & (level_reg != '0) & ~flush;
    do_push = push & (~full | do_pop) & ~flush;
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage: each slot captures din when it is the write target.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == PW'(gi))) begin
          mem_reg[gi] <= din;
        end
      end
    end
  endgenerate

  assign dout  = mem_reg[rd_ptr_reg];
  assign level = level_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues reads to a 1-cycle
// synchronous instruction RAM under a credit that counts the outstanding
// read, buffers responses and hands them to decode with valid/ready.
// The entry layout comes from the package, so AW must match FQ_AW.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int                   DEPTH    = 4,
  parameter  int                   AW       = FQ_AW,
  parameter  logic [FQ_INST_W-1:0] NOP_INST = FQ_NOP_INST,
  localparam int                   LW       = fq_level_w(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           run,
  input  logic           redirect,
  input  logic [AW-1:0]  redirect_pc,
  fetch_queue_if.master  bus,
  output logic [LW-1:0]  level
);

  logic [AW-1:0] fetch_pc_reg;
  logic [AW-1:0] tag_pc1_reg;
  logic          inflight_reg;
  logic          inflight_epoch_reg;
  logic          epoch_reg;

  logic          pop;
  logic          push;
  logic          issue;
  logic [LW:0]   demand;
  logic [LW-1:0] fifo_level;
  logic          has_head;
  fq_entry_t     push_entry;
  fq_entry_t     head_entry;

  // Issue credit: queued + outstanding - leaving must stay below DEPTH.
  // pop implies a non-empty queue, so demand never underflows.
  always_comb begin
    has_head = (fifo_level != '0);
    pop      = has_head & bus.out_ready;
    demand   = {1'b0, fifo_level} + (LW+1)'(inflight_reg) - (LW+1)'(pop);
    issue    = ~reset & run & ~redirect & (demand < (LW+1)'(DEPTH));
    push     = inflight_reg & (inflight_epoch_reg == epoch_reg);
    push_entry.inst = bus.imem_q;
    push_entry.pc1  = tag_pc1_reg;
  end

  // Fetch PC, epoch and the tag of the single read that may be in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_reg       <= '0;
      tag_pc1_reg        <= '0;
      inflight_reg       <= 1'b0;
      inflight_epoch_reg <= 1'b0;
      epoch_reg          <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (redirect) begin
        fetch_pc_reg <= redirect_pc;
        epoch_reg    <= ~epoch_reg;
      end else if (issue) begin
        fetch_pc_reg       <= fetch_pc_reg + AW'(1);
        tag_pc1_reg        <= fetch_pc_reg + AW'(1);
        inflight_epoch_reg <= epoch_reg;
      end
    end
  end

  // Response buffer; a redirect flushes it, dropping any same-cycle
  // response and ignoring any same-cycle pop.
  sync_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fq_entry_t))
  ) u_fifo (
    .clk   (clock),
    .srst  (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .level (fifo_level)
  );

  // Decode-facing outputs; a bubble shows NOP_INST and a zero PC.
  always_comb begin
    bus.imem_addr = fetch_pc_reg;
    bus.imem_rd   = issue;
    bus.out_valid = has_head;
    bus.inst_out  = has_head ? head_entry.inst : NOP_INST;
    bus.pc1_out   = has_head ? head_entry.pc1 : '0;
    level         = fifo_level;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: RAM model returns 16'h1000 + address,
// one task per scenario, cycle numbers counted from reset release.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clock;
  logic        reset;
  logic        run;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [2:0]  level;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue_if #(.AW(16)) bus ();

  fetch_queue #(
    .DEPTH    (4),
    .AW       (16),
    .NOP_INST (16'h0000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .level       (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction RAM, 1-cycle latency; garbage when not read.
  always @(posedge clock) begin
    if (bus.imem_rd) bus.imem_q <= 16'h1000 + bus.imem_addr;
    else             bus.imem_q <= 16'hDEAD;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    run           = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 16'h0000;
    bus.out_ready = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    run           = 1'b1;
    bus.out_ready = 1'b1;
    step();
    @(negedge clock);
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", level); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    n_checks++; if (bus.inst_out !== 16'h0000) begin n_fail++; $display("FAIL reset_inst got=%h want=0000", bus.inst_out); end
    n_checks++; if (bus.pc1_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pc1 got=%h want=0000", bus.pc1_out); end
    n_checks++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd got=%b want=0", bus.imem_rd); end
    n_checks++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got=%h want=0000", bus.imem_addr); end
    step();
  endtask

  task automatic test_stream();
    logic [15:0] exp_inst;
    logic [15:0] exp_pc1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin reset = 1'b0; run = 1'b1; bus.out_ready = 1'b1; end
      @(negedge clock);
      if (bus.out_valid && bus.out_ready) $display("txn stream c=%0d inst=%h pc1=%h", c, bus.inst_out, bus.pc1_out);
      if (c == 0) begin
        n_checks++; if (bus.imem_rd !== 1'b1) begin n_fail++; $display("FAIL stream_first_rd got=%b want=1", bus.imem_rd); end
        n_checks++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL stream_first_addr got=%h want=0000", bus.imem_addr); end
      end
      if (c < 2) begin
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency c=%0d valid got=%b want=0", c, bus.out_valid); end
      end else begin
        exp_inst = 16'h1000 + 16'(c - 2);
        exp_pc1  = 16'(c - 1);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid c=%0d got=%b want=1", c, bus.out_valid); end
        n_checks++; if (bus.inst_out !== exp_inst) begin n_fail++; $display("FAIL stream_inst c=%0d got=%h want=%h", c, bus.inst_out, exp_inst); end
        n_checks++; if (bus.pc1_out !== exp_pc1) begin n_fail++; $display("FAIL stream_pc1 c=%0d got=%h want=%h", c, bus.pc1_out, exp_pc1); end
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_addr;
    int          max_level;
    int          rd_count;
    exp_addr  = 16'h0000;
    max_level = 0;
    rd_count  = 0;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      if (c == 0)  begin reset = 1'b0; run = 1'b1; bus.out_ready = 1'b1; end
      if (c == 3)  bus.out_ready = 1'b0;
      if (c == 13) bus.out_ready = 1'b1;
      @(negedge clock);
      if (int'(level) > max_level) max_level = int'(level);
      if (c >= 6 && c <= 12) rd_count += int'(bus.imem_rd);
      if (c == 5) begin
        n_checks++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL stall_credit_rd got=%b want=0", bus.imem_rd); end
      end
      if (c == 8) begin
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL stall_full_level got=%0d want=4", level); end
        n_checks++; if (bus.inst_out !== 16'h1001) begin n_fail++; $display("FAIL stall_head got=%h want=1001", bus.inst_out); end
      end
      if (bus.out_valid && bus.out_ready) begin
        $display("txn stall c=%0d inst=%h pc1=%h", c, bus.inst_out, bus.pc1_out);
        n_checks++; if (bus.inst_out !== 16'h1000 + exp_addr) begin n_fail++; $display("FAIL stall_order_inst c=%0d got=%h want=%h", c, bus.inst_out, 16'h1000 + exp_addr); end
        n_checks++; if (bus.pc1_out !== exp_addr + 16'h1) begin n_fail++; $display("FAIL stall_order_pc1 c=%0d got=%h want=%h", c, bus.pc1_out, exp_addr + 16'h1); end
        exp_addr = exp_addr + 16'h1;
      end
      step();
    end
    n_checks++; if (max_level != 4) begin n_fail++; $display("FAIL stall_max_level got=%0d want=4", max_level); end
    n_checks++; if (rd_count != 0) begin n_fail++; $display("FAIL stall_issues_while_full got=%0d want=0", rd_count); end
    n_checks++; if (exp_addr !== 16'd14) begin n_fail++; $display("FAIL stall_delivered got=%0d want=14", exp_addr); end
  endtask

  task automatic test_redirect();
    logic [15:0] exp_addr;
    exp_addr = 16'h0000;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin reset = 1'b0; run = 1'b1; bus.out_ready = 1'b1; end
      if (c == 3) bus.out_ready = 1'b0;
      if (c == 5) begin redirect = 1'b1; redirect_pc = 16'h0040; exp_addr = 16'h0040; end
      if (c == 6) redirect = 1'b0;
      if (c == 8) bus.out_ready = 1'b1;
      @(negedge clock);
      if (c == 5) begin
        n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL redir_pre_level got=%0d want=3", level); end
        n_checks++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL redir_no_issue got=%b want=0", bus.imem_rd); end
      end
      if (c == 6) begin
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL redir_flush_level got=%0d want=0", level); end
        n_checks++; if (bus.imem_addr !== 16'h0040) begin n_fail++; $display("FAIL redir_addr got=%h want=0040", bus.imem_addr); end
        n_checks++; if (bus.imem_rd !== 1'b1) begin n_fail++; $display("FAIL redir_resume_rd got=%b want=1", bus.imem_rd); end
      end
      if (c == 6 || c == 7) begin
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale_valid c=%0d got=%b want=0", c, bus.out_valid); end
      end
      if (c == 8) begin
        n_checks++; if (bus.inst_out !== 16'h1040) begin n_fail++; $display("FAIL redir_target_inst got=%h want=1040", bus.inst_out); end
        n_checks++; if (bus.pc1_out !== 16'h0041) begin n_fail++; $display("FAIL redir_target_pc1 got=%h want=0041", bus.pc1_out); end
      end
      if (bus.out_valid && bus.out_ready) begin
        $display("txn redirect c=%0d inst=%h pc1=%h", c, bus.inst_out, bus.pc1_out);
        n_checks++; if (bus.inst_out !== 16'h1000 + exp_addr) begin n_fail++; $display("FAIL redir_order c=%0d got=%h want=%h", c, bus.inst_out, 16'h1000 + exp_addr); end
        exp_addr = exp_addr + 16'h1;
      end
      step();
    end
    n_checks++; if (exp_addr !== 16'h0044) begin n_fail++; $display("FAIL redir_end_addr got=%h want=0044", exp_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin reset = 1'b0; run = 1'b1; bus.out_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE; end
      if (c == 1) redirect = 1'b0;
      @(negedge clock);
      if (bus.out_valid && bus.out_ready) $display("txn wrap c=%0d inst=%h pc1=%h", c, bus.inst_out, bus.pc1_out);
      if (c == 0) begin
        n_checks++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL wrap_redirect_rd got=%b want=0", bus.imem_rd); end
      end
      if (c == 1) begin
        n_checks++; if (bus.imem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr got=%h want=fffe", bus.imem_addr); end
      end
      if (c == 2) begin
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_latency got=%b want=0", bus.out_valid); end
      end
      if (c == 3) begin
        n_checks++; if (bus.inst_out !== 16'h0FFE) begin n_fail++; $display("FAIL wrap_inst0 got=%h want=0ffe", bus.inst_out); end
        n_checks++; if (bus.pc1_out !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pc1_0 got=%h want=ffff", bus.pc1_out); end
      end
      if (c == 4) begin
        n_checks++; if (bus.inst_out !== 16'h0FFF) begin n_fail++; $display("FAIL wrap_inst1 got=%h want=0fff", bus.inst_out); end
        n_checks++; if (bus.pc1_out !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc1_1 got=%h want=0000", bus.pc1_out); end
      end
      if (c == 5) begin
        n_checks++; if (bus.inst_out !== 16'h1000) begin n_fail++; $display("FAIL wrap_inst2 got=%h want=1000", bus.inst_out); end
        n_checks++; if (bus.pc1_out !== 16'h0001) begin n_fail++; $display("FAIL wrap_pc1_2 got=%h want=0001", bus.pc1_out); end
      end
      step();
    end
  endtask

  task automatic test_run_gate();
    logic [15:0] exp_addr;
    int          rd_count;
    exp_addr = 16'h0000;
    rd_count = 0;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if (c == 0)  begin reset = 1'b0; run = 1'b1; bus.out_ready = 1'b0; end
      if (c == 3)  run = 1'b0;
      if (c == 5)  bus.out_ready = 1'b1;
      if (c == 10) run = 1'b1;
      @(negedge clock);
      if (c >= 3 && c <= 9) rd_count += int'(bus.imem_rd);
      if (c == 4) begin
        n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL run_inflight_landed got=%0d want=3", level); end
      end
      if (c == 9) begin
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL run_drain_level got=%0d want=0", level); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL run_drain_valid got=%b want=0", bus.out_valid); end
        n_checks++; if (bus.inst_out !== 16'h0000) begin n_fail++; $display("FAIL run_drain_nop got=%h want=0000", bus.inst_out); end
        n_checks++; if (bus.imem_addr !== 16'h0003) begin n_fail++; $display("FAIL run_hold_pc got=%h want=0003", bus.imem_addr); end
      end
      if (c == 10) begin
        n_checks++; if (bus.imem_rd !== 1'b1) begin n_fail++; $display("FAIL run_resume_rd got=%b want=1", bus.imem_rd); end
      end
      if (bus.out_valid && bus.out_ready) begin
        $display("txn run c=%0d inst=%h pc1=%h", c, bus.inst_out, bus.pc1_out);
        n_checks++; if (bus.inst_out !== 16'h1000 + exp_addr) begin n_fail++; $display("FAIL run_order c=%0d got=%h want=%h", c, bus.inst_out, 16'h1000 + exp_addr); end
        exp_addr = exp_addr + 16'h1;
      end
      step();
    end
    n_checks++; if (rd_count != 0) begin n_fail++; $display("FAIL run_gated_issues got=%0d want=0", rd_count); end
    n_checks++; if (exp_addr !== 16'd6) begin n_fail++; $display("FAIL run_delivered got=%0d want=6", exp_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin reset = 1'b0; run = 1'b1; bus.out_ready = 1'b0; end
      if (c == 5) begin reset = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080; bus.out_ready = 1'b1; end
      if (c == 6) begin reset = 1'b0; redirect = 1'b0; end
      if (c == 8) reset = 1'b1;
      if (c == 9) reset = 1'b0;
      @(negedge clock);
      if (bus.out_valid && bus.out_ready) $display("txn rstmid c=%0d inst=%h pc1=%h", c, bus.inst_out, bus.pc1_out);
      if (c == 5) begin
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL rstmid_pre_full got=%0d want=4", level); end
      end
      if (c == 6) begin
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rstmid_level got=%0d want=0", level); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b want=0", bus.out_valid); end
        n_checks++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rstmid_pc got=%h want=0000", bus.imem_addr); end
      end
      if (c == 7 || c == 9 || c == 10) begin
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rstmid_no_stale c=%0d got=%0d want=0", c, level); end
      end
      if (c == 8 || c == 11) begin
        n_checks++; if (bus.inst_out !== 16'h1000) begin n_fail++; $display("FAIL rstmid_first_inst c=%0d got=%h want=1000", c, bus.inst_out); end
        n_checks++; if (bus.pc1_out !== 16'h0001) begin n_fail++; $display("FAIL rstmid_first_pc1 c=%0d got=%h want=0001", c, bus.pc1_out); end
      end
      step();
    end
  endtask

  initial begin
    reset         = 1'b1;
    run           = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 16'h0000;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_run_gate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
